wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the MIPS pipeline; the writer side of the general-purpose register file's write port.
- Accepts retiring instructions from the MEM stage over a valid/ready handshake and buffers them in a small FIFO.
- Performs load-data byte/halfword extraction with sign or zero extension.
- Drives the register-file write port (o_we/o_waddr/o_wdata) from flops, at most one write per cycle.

Parameters:
DEPTH, 2, buffer entries (power of 2, >=2)
DATA_W, 32, register data width
ADDR_W, 5, register address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (rst==0 resets)
i_valid  input  1  MEM stage presents an instruction
o_ready  output  1  stage can accept this cycle
i_wreg  input  1  instruction writes a GPR
i_waddr  input  ADDR_W  destination register
i_alures  input  DATA_W  ALU/non-load result
i_memdata  input  DATA_W  raw word read from data memory
i_ldop  input  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6-7 reserved
i_addr_lo  input  2  load address bits [1:0]
i_hold  input  1  block retirement this cycle (debug halt)
o_we  output  1  register-file write enable
o_waddr  output  ADDR_W  register-file write address
o_wdata  output  DATA_W  register-file write data

Behaviour:
- Reset (rst==0, async): FIFO empty, pointers/count 0. o_we=0, o_waddr=0, o_wdata=0, o_ready=1 once count is 0.
- Accept: on a rising edge with i_valid && o_ready, push {wreg, waddr, wdata_final}.
- wdata_final is computed on entry. Little-endian lanes: byte k = i_memdata[8k+7:8k].
  - LB/LBU: byte i_addr_lo, sign/zero extended.
  - LH/LHU: halfword i_addr_lo[1], sign/zero extended; i_addr_lo[0] ignored, misalignment is trapped upstream.
  - LW: i_memdata.
  - ldop 0, 6, 7: i_alures.
- o_ready = (count != DEPTH). It depends on registered count only; no combinational path from i_valid or i_hold.
- Retire: each cycle with count>0 and i_hold==0, pop the head.
- Output register, loaded on every edge:
  - o_we <= pop && head.wreg && head.waddr!=0.
  - o_waddr/o_wdata <= head fields when pop.
  - Otherwise o_we <= 0 and o_waddr/o_wdata hold their previous values.
- Entries with wreg==0 or waddr==0 still consume a retire cycle but produce no write. $0 is never written.
- Latency: an instruction accepted at edge N appears on o_we at edge N+1 at the earliest, when the FIFO was empty and there is no hold.
- Simultaneous push and pop in one cycle: count unchanged, pointers both advance. Full FIFO: o_ready=0, so no push.
- Ordering is strict FIFO. Pointers wrap modulo DEPTH.
- i_hold==1: no pop, o_we=0 next edge, buffer contents preserved, accepts continue until full.
- Reset mid-operation discards all buffered entries; no write is issued after reset deasserts until a new accept.

Optional Feature:
- Macro: WB_STAT_EN.
- Defined: adds output port o_wr_cnt [31:0]. It increments on every edge where o_we is asserted, wraps at 2^32, and resets to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package wb_pkg holds:
  - ldop_e enum (LD_NONE, LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW).
  - wb_entry_t packed struct {wreg, waddr, wdata}.
  - Width constants matching the project's register-bus defines.
- One sub-module, wb_load_align: purely combinational; inputs ldop, addr_lo, memdata, alures; output wdata_final. Separate so it can be unit-tested exhaustively.
- FIFO storage and output flops live in wb_stage.

Test Plan:
1. Reset then single accept (wreg=1, waddr=5, ldop=0, alures=0x1234_5678) -> next edge o_we=1, o_waddr=5, o_wdata=0x1234_5678; following edge o_we=0.
2. Load extraction with memdata=0x80FF_7F01:
   - LB addr_lo=3 -> 0xFFFF_FF80.
   - LBU addr_lo=3 -> 0x0000_0080.
   - LH addr_lo=2 -> 0xFFFF_80FF.
   - LHU addr_lo=0 -> 0x0000_7F01.
   - LW -> 0x80FF_7F01.
3. waddr=0 with wreg=1, and wreg=0 with waddr=7 -> o_we stays 0; next entry still retires one cycle later.
4. i_hold=1 while three valids are offered -> two accepted, o_ready=0 on the third. Release hold -> writes emerge in order on consecutive cycles, then o_ready=1.
5. Back-to-back valids, no hold -> o_ready stays 1, one write per cycle, order preserved; waddr sequence 1,2,3,4 observed.
6. Assert rst low with 2 entries buffered -> o_we=0 immediately, count=0. After release, no write until a new accept. With WB_STAT_EN, o_wr_cnt=0 after reset and equals the number of o_we pulses in scenarios 1-5.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and widths for the MIPS writeback stage.
// Load opcode encoding, buffered entry layout and register-bus widths.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_LDOP_W = 3;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5
    } ldop_e;

    typedef struct packed {
        logic                 wreg;
        logic [WB_ADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load-data lane extraction with sign/zero extension; purely combinational.
// Little-endian: byte k lives in memdata[8k+7:8k]; halfword chosen by addr_lo[1].
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W
) (
    input  logic [WB_LDOP_W-1:0] ldop,
    input  logic [1:0]           addr_lo,
    input  logic [DATA_W-1:0]    memdata,
    input  logic [DATA_W-1:0]    alures,
    output logic [DATA_W-1:0]    wdata_final
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword lanes.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (addr_lo)
            2'd0:    byte_s = memdata[7:0];
            2'd1:    byte_s = memdata[15:8];
            2'd2:    byte_s = memdata[23:16];
            2'd3:    byte_s = memdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = memdata[31:16];
        end else begin
            half_s = memdata[15:0];
        end
    end

    // Extend the selected lane; reserved opcodes fall back to the ALU result.
    always_comb begin
        wdata_final = alures;
        case (ldop_e'(ldop))
            LD_LB:   wdata_final = {{(DATA_W-8){byte_s[7]}}, byte_s};
            LD_LBU:  wdata_final = {{(DATA_W-8){1'b0}}, byte_s};
            LD_LH:   wdata_final = {{(DATA_W-16){half_s[15]}}, half_s};
            LD_LHU:  wdata_final = {{(DATA_W-16){1'b0}}, half_s};
            LD_LW:   wdata_final = memdata;
            default: wdata_final = alures;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: small retire FIFO feeding a registered GPR write port.
// Optional WB_STAT_EN adds o_wr_cnt, a wrapping count of issued register writes.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_wreg,
    input  logic [ADDR_W-1:0]    i_waddr,
    input  logic [DATA_W-1:0]    i_alures,
    input  logic [DATA_W-1:0]    i_memdata,
    input  logic [WB_LDOP_W-1:0] i_ldop,
    input  logic [1:0]           i_addr_lo,
    input  logic                 i_hold,
    output logic                 o_we,
    output logic [ADDR_W-1:0]    o_waddr,
    output logic [DATA_W-1:0]    o_wdata
`ifdef WB_STAT_EN
    ,
    output logic [31:0]          o_wr_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] wdata_final_s;
    logic              wreg_mem_r  [DEPTH];
    logic [ADDR_W-1:0] waddr_mem_r [DEPTH];
    logic [DATA_W-1:0] wdata_mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic              push_s;
    logic              pop_s;
    logic              we_next_s;

    wb_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .ldop        (i_ldop),
        .addr_lo     (i_addr_lo),
        .memdata     (i_memdata),
        .alures      (i_alures),
        .wdata_final (wdata_final_s)
    );

    // Ready comes from the registered occupancy only, so MEM sees no loop through i_valid.
    assign o_ready = (count_r != CNT_W'(DEPTH));

    // Handshake, occupancy update and write qualification for the head entry.
    always_comb begin
        push_s       = i_valid && o_ready;
        pop_s        = (count_r != {CNT_W{1'b0}}) && !i_hold;
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_W'(1'b1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_W'(1'b1);
        end else begin
            count_next_s = count_r;
        end
        we_next_s = pop_s && wreg_mem_r[rd_ptr_r]
                    && (waddr_mem_r[rd_ptr_r] != {ADDR_W{1'b0}});
    end

    // Entry storage; contents are only meaningful under count_r, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            wreg_mem_r[wr_ptr_r]  <= i_wreg;
            waddr_mem_r[wr_ptr_r] <= i_waddr;
            wdata_mem_r[wr_ptr_r] <= wdata_final_s;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r <= count_next_s;
        end
    end

    // Register-file write port; address/data keep their last popped values when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_we    <= 1'b0;
            o_waddr <= {ADDR_W{1'b0}};
            o_wdata <= {DATA_W{1'b0}};
        end else begin
            o_we <= we_next_s;
            if (pop_s) begin
                o_waddr <= waddr_mem_r[rd_ptr_r];
                o_wdata <= wdata_mem_r[rd_ptr_r];
            end
        end
    end

`ifdef WB_STAT_EN
    // Count each edge on which a register write is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_wr_cnt <= 32'd0;
        end else if (we_next_s) begin
            o_wr_cnt <= o_wr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours WB_STAT_EN when defined.
module tb_wb_stage;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic              o_ready;
    logic              i_wreg;
    logic [ADDR_W-1:0] i_waddr;
    logic [DATA_W-1:0] i_alures;
    logic [DATA_W-1:0] i_memdata;
    logic [2:0]        i_ldop;
    logic [1:0]        i_addr_lo;
    logic              i_hold;
    logic              o_we;
    logic [ADDR_W-1:0] o_waddr;
    logic [DATA_W-1:0] o_wdata;
`ifdef WB_STAT_EN
    logic [31:0]       o_wr_cnt;
`endif

    always #5 clk = ~clk;

    wb_stage #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_wreg    (i_wreg),
        .i_waddr   (i_waddr),
        .i_alures  (i_alures),
        .i_memdata (i_memdata),
        .i_ldop    (i_ldop),
        .i_addr_lo (i_addr_lo),
        .i_hold    (i_hold),
        .o_we      (o_we),
        .o_waddr   (o_waddr),
        .o_wdata   (o_wdata)
`ifdef WB_STAT_EN
        ,
        .o_wr_cnt  (o_wr_cnt)
`endif
    );

    typedef struct {
        bit        wreg;
        bit [4:0]  waddr;
        bit [31:0] wdata;
    } ent_t;

    ent_t      mq[$];
    bit        exp_we;
    bit [4:0]  exp_waddr;
    bit [31:0] exp_wdata;
    bit        exp_ready;
    logic      obs_ready;
    int        writes_model;
    int        pass_cnt;
    int        total_cnt;

    // Reference load extraction using shifts and masks on the raw word.
    function automatic bit [31:0] ref_align(input int op, input int lo,
                                            input bit [31:0] mem, input bit [31:0] alu);
        bit [31:0] b;
        bit [31:0] h;
        b = (mem >> (8 * lo)) & 32'h0000_00FF;
        h = (mem >> (16 * (lo / 2))) & 32'h0000_FFFF;
        case (op)
            1:       return (b >= 32'd128) ? b - 32'd256 : b;
            2:       return b;
            3:       return (h >= 32'd32768) ? h - 32'd65536 : h;
            4:       return h;
            5:       return mem;
            default: return alu;
        endcase
    endfunction

    // One clock: drive inputs, advance the model across the edge, land 1 time unit after it.
    task automatic cycle(input bit v, input bit wr, input bit [4:0] wa, input bit [31:0] alu,
                         input bit [31:0] mem, input bit [2:0] op, input bit [1:0] lo,
                         input bit hd);
        ent_t e;
        bit   push;
        bit   pop;
        i_valid   = v;
        i_wreg    = wr;
        i_waddr   = wa;
        i_alures  = alu;
        i_memdata = mem;
        i_ldop    = op;
        i_addr_lo = lo;
        i_hold    = hd;
        obs_ready = o_ready;
        exp_ready = (mq.size() < DEPTH);
        push = v && exp_ready;
        pop  = (mq.size() > 0) && !hd;
        @(posedge clk);
        if (pop) begin
            e = mq.pop_front();
            exp_we    = e.wreg && (e.waddr != 5'd0);
            exp_waddr = e.waddr;
            exp_wdata = e.wdata;
        end else begin
            exp_we = 1'b0;
        end
        if (push) begin
            e.wreg  = wr;
            e.waddr = wa;
            e.wdata = ref_align(int'(op), int'(lo), mem, alu);
            mq.push_back(e);
        end
        if (exp_we) writes_model++;
        #1;
    endtask

    task automatic idle(input bit hd);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 2'd0, hd);
    endtask

    task automatic drain();
        while (mq.size() > 0) idle(1'b0);
        idle(1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_valid = 1'b0; i_wreg = 1'b0; i_waddr = 5'd0; i_alures = 32'd0;
        i_memdata = 32'd0; i_ldop = 3'd0; i_addr_lo = 2'd0; i_hold = 1'b0;
        #12;
        total_cnt++; if (o_we !== 1'b0) $display("FAIL reset_we: got %b want 0", o_we); else pass_cnt++;
        total_cnt++; if (o_waddr !== 5'd0) $display("FAIL reset_waddr: got %0d want 0", o_waddr); else pass_cnt++;
        total_cnt++; if (o_wdata !== 32'd0) $display("FAIL reset_wdata: got %h want 0", o_wdata); else pass_cnt++;
        total_cnt++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_ready); else pass_cnt++;
`ifdef WB_STAT_EN
        total_cnt++; if (o_wr_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", o_wr_cnt); else pass_cnt++;
`endif
        rst = 1'b1;
        idle(1'b0);
    endtask

    task automatic test_single();
        cycle(1'b1, 1'b1, 5'd5, 32'h1234_5678, 32'hCAFE_0000, 3'd0, 2'd0, 1'b0);
        total_cnt++; if (o_we !== 1'b0) $display("FAIL single_early: got %b want 0", o_we); else pass_cnt++;
        idle(1'b0);
        total_cnt++; if (o_we !== 1'b1) $display("FAIL single_we: got %b want 1", o_we); else pass_cnt++;
        total_cnt++; if (o_waddr !== 5'd5) $display("FAIL single_waddr: got %0d want 5", o_waddr); else pass_cnt++;
        total_cnt++; if (o_wdata !== 32'h1234_5678) $display("FAIL single_wdata: got %h want 12345678", o_wdata); else pass_cnt++;
        idle(1'b0);
        total_cnt++; if (o_we !== 1'b0) $display("FAIL single_we_drop: got %b want 0", o_we); else pass_cnt++;
        total_cnt++; if (o_waddr !== 5'd5) $display("FAIL single_hold_addr: got %0d want 5", o_waddr); else pass_cnt++;
    endtask

    task automatic test_load();
        bit [2:0]  ops  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        bit [1:0]  los  [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
        bit [31:0] want [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 5'(10 + i), 32'hDEAD_BEEF, 32'h80FF_7F01, ops[i], los[i], 1'b0);
            idle(1'b0);
            total_cnt++;
            if (o_we !== 1'b1 || o_wdata !== want[i])
                $display("FAIL load_op%0d: got we=%b data=%h want we=1 data=%h", ops[i], o_we, o_wdata, want[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_nowrite();
        cycle(1'b1, 1'b1, 5'd0, 32'h1111_1111, 32'd0, 3'd0, 2'd0, 1'b0);
        cycle(1'b1, 1'b0, 5'd7, 32'h2222_2222, 32'd0, 3'd0, 2'd0, 1'b0);
        total_cnt++; if (o_we !== 1'b0) $display("FAIL nowrite_r0: got %b want 0", o_we); else pass_cnt++;
        cycle(1'b1, 1'b1, 5'd9, 32'h3333_3333, 32'd0, 3'd0, 2'd0, 1'b0);
        total_cnt++; if (o_we !== 1'b0) $display("FAIL nowrite_wreg0: got %b want 0", o_we); else pass_cnt++;
        idle(1'b0);
        total_cnt++;
        if (o_we !== 1'b1 || o_waddr !== 5'd9 || o_wdata !== 32'h3333_3333)
            $display("FAIL nowrite_next: got we=%b addr=%0d data=%h want we=1 addr=9 data=33333333", o_we, o_waddr, o_wdata);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_hold();
        bit rdy_want [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 5'(20 + i), 32'h0000_0100 + 32'(i), 32'd0, 3'd0, 2'd0, 1'b1);
            total_cnt++;
            if (obs_ready !== rdy_want[i] || o_we !== 1'b0)
                $display("FAIL hold_accept%0d: got ready=%b we=%b want ready=%b we=0", i, obs_ready, o_we, rdy_want[i]);
            else pass_cnt++;
        end
        for (int i = 0; i < 2; i++) begin
            idle(1'b0);
            total_cnt++;
            if (o_we !== 1'b1 || o_waddr !== 5'(20 + i) || o_wdata !== 32'h0000_0100 + 32'(i))
                $display("FAIL hold_release%0d: got we=%b addr=%0d data=%h want addr=%0d", i, o_we, o_waddr, o_wdata, 20 + i);
            else pass_cnt++;
        end
        total_cnt++; if (o_ready !== 1'b1) $display("FAIL hold_ready_back: got %b want 1", o_ready); else pass_cnt++;
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) cycle(1'b1, 1'b1, 5'(i), 32'h100 * 32'(i), 32'd0, 3'd0, 2'd0, 1'b0);
            else idle(1'b0);
            if (i <= 4) begin
                total_cnt++; if (obs_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, obs_ready); else pass_cnt++;
            end
            if (i >= 2) begin
                total_cnt++;
                if (o_we !== 1'b1 || o_waddr !== 5'(i - 1) || o_wdata !== 32'h100 * 32'(i - 1))
                    $display("FAIL b2b_write%0d: got we=%b addr=%0d data=%h want addr=%0d", i - 1, o_we, o_waddr, o_wdata, i - 1);
                else pass_cnt++;
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom), $urandom, $urandom,
                  3'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0));
            total_cnt++;
            if (obs_ready !== exp_ready || o_we !== exp_we || o_waddr !== exp_waddr || o_wdata !== exp_wdata)
                $display("FAIL random%0d: got rdy=%b we=%b a=%0d d=%h want rdy=%b we=%b a=%0d d=%h", n,
                         obs_ready, o_we, o_waddr, o_wdata, exp_ready, exp_we, exp_waddr, exp_wdata);
            else pass_cnt++;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b1, 5'd3, 32'hABCD_0003, 32'd0, 3'd0, 2'd0, 1'b0);
        idle(1'b0);
        cycle(1'b1, 1'b1, 5'd4, 32'h4444_4444, 32'd0, 3'd0, 2'd0, 1'b1);
        cycle(1'b1, 1'b1, 5'd6, 32'h6666_6666, 32'd0, 3'd0, 2'd0, 1'b1);
`ifdef WB_STAT_EN
        total_cnt++; if (o_wr_cnt !== 32'(writes_model)) $display("FAIL stat_cnt: got %0d want %0d", o_wr_cnt, writes_model); else pass_cnt++;
`endif
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (o_we !== 1'b0 || o_waddr !== 5'd0 || o_wdata !== 32'd0 || o_ready !== 1'b1)
            $display("FAIL midreset_outputs: got we=%b a=%0d d=%h rdy=%b want 0/0/0/1", o_we, o_waddr, o_wdata, o_ready);
        else pass_cnt++;
`ifdef WB_STAT_EN
        total_cnt++; if (o_wr_cnt !== 32'd0) $display("FAIL midreset_cnt: got %0d want 0", o_wr_cnt); else pass_cnt++;
`endif
        mq.delete();
        exp_we = 1'b0; exp_waddr = 5'd0; exp_wdata = 32'd0; writes_model = 0;
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            total_cnt++; if (o_we !== 1'b0) $display("FAIL midreset_quiet%0d: got %b want 0", i, o_we); else pass_cnt++;
        end
        cycle(1'b1, 1'b1, 5'd8, 32'h8888_8888, 32'd0, 3'd0, 2'd0, 1'b0);
        idle(1'b0);
        total_cnt++;
        if (o_we !== 1'b1 || o_waddr !== 5'd8 || o_wdata !== 32'h8888_8888)
            $display("FAIL midreset_new: got we=%b a=%0d d=%h want 1/8/88888888", o_we, o_waddr, o_wdata);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        writes_model = 0;
        exp_we = 1'b0;
        exp_waddr = 5'd0;
        exp_wdata = 32'd0;
        test_reset();
        test_single();
        test_load();
        test_nowrite();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
